udma_evt_serializer: RTL and testbench
======================================

Name: udma_evt_serializer

Overview:
- Sits directly upstream of the uDMA subsystem event input and feeds it.
- Takes N_EVT single-cycle SoC event pulses and latches each as a pending bit.
- Arbitrates the pending bits round-robin and queues event IDs in a FIFO.
- Presents the queue as the valid/data/ready byte stream that drives event_valid_i / event_data_i / event_ready_o of the uDMA subsystem.

Parameters:
- N_EVT, 32, number of event input lines; legal range 2..256.
- FIFO_DEPTH, 8, ID queue depth; power of two, minimum 2.
- LOST_CNT_WIDTH, 8, width of the saturating lost-event counter.

Ports:
- sys_clk_i  in  1  single clock, all logic on its rising edge.
- sys_rst_i  in  1  reset, asynchronous assert, active-high.
- evt_i  in  N_EVT  event pulses; each bit is 1 cycle per occurrence.
- evt_mask_i  in  N_EVT  1 = line enabled; masked pulses are dropped and never counted lost.
- event_valid_o  out  1  stream valid; connects to the subsystem event_valid_i.
- event_data_o  out  8  event ID, zero-extended line index; connects to event_data_i.
- event_ready_i  in  1  stream ready; driven from the subsystem event_ready_o.
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current queue occupancy.
- lost_o  out  1  sticky flag: at least one event was lost.
- lost_cnt_o  out  LOST_CNT_WIDTH  saturating count of lost events.
- lost_clr_i  in  1  single-cycle pulse; clears lost_o and lost_cnt_o.

Behaviour:
- Reset values:
  - pending register, FIFO pointers and count, lost_o, lost_cnt_o: 0.
  - Round-robin pointer: 0.
  - event_valid_o = 0; event_data_o = 0; fifo_level_o = 0.
  - Reset mid-operation discards all pending bits and queued IDs. event_valid_o drops immediately (asynchronous).
- Capture stage, per line i, each cycle:
  - set_i = evt_i[i] & evt_mask_i[i].
  - pend_next[i] = set_i | (pend[i] & ~grant[i]).
  - If set_i & pend[i] & ~grant[i], the event is lost.
  - If set_i & grant[i] in the same cycle, the new pulse is re-latched and is not lost.
- Lost accounting:
  - The number of lost lines in one cycle (popcount) is added to lost_cnt_o, saturating at all-ones.
  - lost_o is set when that count is nonzero.
  - lost_clr_i has priority over a same-cycle increment: result is 0/0, and that cycle's losses are discarded.
- Arbiter (combinational from the registered pend, masked by the current evt_mask_i):
  - Searches from rr_ptr upward with wrap-around to N_EVT-1 → 0, and selects the first set bit.
  - A grant occurs only if one bit is selected and the FIFO is not full at the start of the cycle.
  - On a grant of line k: push k into the FIFO, clear pend[k], and set rr_ptr to (k+1) mod N_EVT.
  - With no grant, rr_ptr holds.
  - At most one push per cycle.
- Masking a line that is already pending holds its pending bit but blocks its grant. The grant resumes when the line is unmasked.
- FIFO:
  - Registered storage; event_valid_o = not empty; event_data_o = head entry.
  - Pop when event_valid_o & event_ready_i.
  - A push requires not-full at the start of the cycle. A same-cycle pop does not make room; there is no full-bypass.
  - When not full, push and pop in the same cycle are both performed and the level is unchanged.
  - event_data_o is held stable while valid and not ready (AXI-style: valid never drops without a handshake).
- Latency:
  - Pulse in cycle t → pend set at the t+1 edge → pushed during cycle t+1 if it wins and the FIFO has room.
  - event_valid_o is high in cycle t+2 (2-cycle minimum latency).
- Throughput: 1 ID per cycle when ready is held high.
- Backpressure: with the FIFO full, pending bits accumulate. One outstanding occurrence per line is kept; repeats count as lost.
- Widths: IDs are $clog2(N_EVT) bits, zero-extended to 8. The level counter must represent FIFO_DEPTH (full).

Test Plan:
1. Reset, then a pulse on line 5 at cycle t, ready=1 → event_valid_o=1 with data 0x05 at t+2, for exactly 1 cycle; fifo_level_o returns to 0.
2. Lines 3, 7, 31 pulse together, rr_ptr=0, ready=1 → IDs 3, 7, 31 in consecutive cycles. A second burst of 3 and 7 issued immediately after is served 3 then 7 (pointer wrapped past 31).
3. ready=0, pulses on lines 0..9 spread over 10 cycles, FIFO_DEPTH=8:
   - Level saturates at 8 and event_valid_o stays high with data 0x00 held.
   - Lines 8 and 9 remain pending.
   - After ready=1, order is 0..9 with no loss.
4. ready=0 with FIFO full, line 4 pulses 3 times → lost_cnt_o=2 and lost_o=1. lost_clr_i pulsed in the same cycle as a 4th pulse → both read 0 the next cycle.
5. evt_mask_i[6]=0, pulse line 6 → no output and no loss. Line 2 pending while masked → not granted until unmasked, then ID 0x02 emitted.
6. Assert sys_rst_i asynchronously with 5 queued IDs and pending bits set → event_valid_o=0 immediately; after release the level is 0, with no stale IDs and no stale pending bits.

Source files
------------

// File: rtl/udma_evt_serializer.sv
// udma_evt_serializer: latches SoC event pulses, arbitrates them round-robin and streams the IDs to the uDMA event input.
// Ports:
//   sys_clk_i, sys_rst_i        clock and async active-high reset
//   evt_i, evt_mask_i           event pulses and per-line enables
//   event_valid_o/data_o/ready_i  ID byte stream toward the uDMA subsystem
//   fifo_level_o                queue occupancy
//   lost_o, lost_cnt_o, lost_clr_i  sticky lost flag, saturating lost count, clear pulse
module udma_evt_serializer #(
   parameter int N_EVT          = 32,
   parameter int FIFO_DEPTH     = 8,
   parameter int LOST_CNT_WIDTH = 8
) (
   input  logic                          sys_clk_i,
   input  logic                          sys_rst_i,
   input  logic [N_EVT-1:0]              evt_i,
   input  logic [N_EVT-1:0]              evt_mask_i,
   output logic                          event_valid_o,
   output logic [7:0]                    event_data_o,
   input  logic                          event_ready_i,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
   output logic                          lost_o,
   output logic [LOST_CNT_WIDTH-1:0]     lost_cnt_o,
   input  logic                          lost_clr_i
);
   localparam int IW = $clog2(N_EVT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int SW = LOST_CNT_WIDTH + 9;
   logic [N_EVT-1:0] pend, req, rot, set, grant, lost_vec;
   logic [IW-1:0]    rr_ptr, off, sel_idx;
   logic [IW:0]      abs_idx;
   logic             sel_vld, full, push, pop;
   logic [IW-1:0]    mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [LW-1:0]    count;
   logic [8:0]       lost_n;
   logic [SW-1:0]    sum;
   assign set = evt_i & evt_mask_i;
   assign req = pend & evt_mask_i;
   // rotate so that bit 0 is rr_ptr; the lowest set bit is the winner's offset
   assign rot = N_EVT'({req, req} >> rr_ptr);
   always_comb begin
      sel_vld = 1'b0;
      off = '0;
      for (int j = N_EVT - 1; j >= 0; j--)
         if (rot[j]) begin
            sel_vld = 1'b1;
            off = IW'(j);
         end
   end
   assign abs_idx = {1'b0, rr_ptr} + {1'b0, off};
   assign sel_idx = abs_idx >= (IW+1)'(N_EVT) ? IW'(abs_idx - (IW+1)'(N_EVT)) : IW'(abs_idx);
   assign full = count == LW'(FIFO_DEPTH);
   assign push = sel_vld & ~full;
   assign pop  = event_valid_o & event_ready_i;
   always_comb begin
      grant = '0;
      grant[sel_idx] = push;
   end
   assign lost_vec = set & pend & ~grant;
   assign lost_n = 9'($countones(lost_vec));
   assign sum = SW'(lost_cnt_o) + SW'(lost_n);
   assign event_valid_o = |count;
   assign event_data_o = event_valid_o ? 8'(mem[rd_ptr]) : 8'h00;
   assign fifo_level_o = count;
   always_ff @(posedge sys_clk_i or posedge sys_rst_i)
      if (sys_rst_i) begin
         pend <= '0;
         rr_ptr <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         lost_o <= 1'b0;
         lost_cnt_o <= '0;
      end else begin
         // a pulse coinciding with its own grant re-latches rather than being lost
         pend <= set | (pend & ~grant);
         if (push) begin
            rr_ptr <= sel_idx == IW'(N_EVT - 1) ? '0 : sel_idx + 1'b1;
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + LW'(push) - LW'(pop);
         if (lost_clr_i) begin
            lost_o <= 1'b0;
            lost_cnt_o <= '0;
         end else if (|lost_n) begin
            lost_o <= 1'b1;
            lost_cnt_o <= |sum[SW-1:LOST_CNT_WIDTH] ? '1 : sum[LOST_CNT_WIDTH-1:0];
         end
      end
   always_ff @(posedge sys_clk_i)
      if (push) mem[wr_ptr] <= sel_idx;
endmodule

// File: tb/tb_udma_evt_serializer.sv
// tb_udma_evt_serializer: directed stimulus with a queue-based reference model checked every cycle plus literal expectations.
module tb_udma_evt_serializer;
   localparam int N = 32;
   localparam int DEPTH = 8;
   logic        clk = 1'b0, rst = 1'b1;
   logic [N-1:0] evt = '0, mask = '1;
   logic        ready = 1'b0, clr = 1'b0;
   logic        event_valid_o, lost_o;
   logic [7:0]  event_data_o, lost_cnt_o;
   logic [3:0]  fifo_level_o;
   int checks = 0, errors = 0;
   bit mpend [N];
   int mrr, mcnt, g, nl;
   bit mlost;
   int q[$];
   int got[$];
   bit seen;
   always #5 clk = ~clk;
   udma_evt_serializer dut (
      .sys_clk_i(clk), .sys_rst_i(rst), .evt_i(evt), .evt_mask_i(mask),
      .event_valid_o(event_valid_o), .event_data_o(event_data_o), .event_ready_i(ready),
      .fifo_level_o(fifo_level_o), .lost_o(lost_o), .lost_cnt_o(lost_cnt_o), .lost_clr_i(clr)
   );
   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask
   // reference: pending set, FIFO as a queue, round-robin search from last winner + 1
   always @(posedge clk or posedge rst)
      if (rst) begin
         foreach (mpend[i]) mpend[i] = 1'b0;
         q.delete();
         mrr = 0; mcnt = 0; mlost = 1'b0;
      end else begin
         g = -1;
         nl = 0;
         for (int j = 0; j < N; j++)
            if (g < 0 && mpend[(mrr + j) % N] && mask[(mrr + j) % N]) g = (mrr + j) % N;
         if (q.size() >= DEPTH) g = -1;
         for (int i = 0; i < N; i++)
            if (evt[i] && mask[i] && mpend[i] && i != g) nl++;
         if (q.size() > 0 && ready) void'(q.pop_front());
         if (g >= 0) begin
            q.push_back(g);
            mpend[g] = 1'b0;
            mrr = (g + 1) % N;
         end
         for (int i = 0; i < N; i++)
            if (evt[i] && mask[i]) mpend[i] = 1'b1;
         if (clr) begin
            mcnt = 0;
            mlost = 1'b0;
         end else if (nl > 0) begin
            mcnt = (mcnt + nl > 255) ? 255 : mcnt + nl;
            mlost = 1'b1;
         end
      end
   always @(negedge clk)
      if (!rst) begin
         chk("m_valid", event_valid_o, q.size() != 0);
         if (q.size() != 0) chk("m_data", event_data_o, q[0]);
         chk("m_level", fifo_level_o, q.size());
         chk("m_lost", lost_o, mlost);
         chk("m_lost_cnt", lost_cnt_o, mcnt);
      end
   task automatic do_reset();
      evt = '0; mask = '1; ready = 1'b0; clr = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask
   task automatic pulse(input logic [N-1:0] v);
      evt = v;
      @(negedge clk);
      evt = '0;
   endtask
   task automatic wait_n(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask
   initial begin
      @(negedge clk);
      chk("rst_valid", event_valid_o, 0);
      chk("rst_data", event_data_o, 0);
      chk("rst_level", fifo_level_o, 0);
      chk("rst_lost", lost_o, 0);
      chk("rst_lost_cnt", lost_cnt_o, 0);
      do_reset();
      // single event, two-cycle latency
      ready = 1'b1;
      pulse(32'h1 << 5);
      chk("t1_early", event_valid_o, 0);
      @(negedge clk);
      chk("t1_valid", event_valid_o, 1);
      chk("t1_data", event_data_o, 5);
      @(negedge clk);
      chk("t1_gone", event_valid_o, 0);
      chk("t1_level", fifo_level_o, 0);
      // round-robin burst and wrap
      do_reset();
      ready = 1'b1;
      pulse((32'h1 << 3) | (32'h1 << 7) | (32'h1 << 31));
      @(negedge clk);
      chk("t2_id0", event_data_o, 3);
      @(negedge clk);
      chk("t2_id1", event_data_o, 7);
      evt = (32'h1 << 3) | (32'h1 << 7);
      @(negedge clk);
      evt = '0;
      chk("t2_id2", event_data_o, 31);
      @(negedge clk);
      chk("t2_id3", event_data_o, 3);
      @(negedge clk);
      chk("t2_id4", event_data_o, 7);
      @(negedge clk);
      chk("t2_empty", event_valid_o, 0);
      chk("t2_nolost", lost_cnt_o, 0);
      // backpressure fills the FIFO, excess stays pending
      do_reset();
      for (int i = 0; i < 10; i++) pulse(32'h1 << i);
      wait_n(3);
      chk("t3_level", fifo_level_o, 8);
      chk("t3_valid", event_valid_o, 1);
      chk("t3_head", event_data_o, 0);
      @(negedge clk);
      chk("t3_head_held", event_data_o, 0);
      ready = 1'b1;
      got.delete();
      for (int c = 0; c < 30 && got.size() < 10; c++) begin
         if (event_valid_o) got.push_back(event_data_o);
         @(negedge clk);
      end
      chk("t3_count", got.size(), 10);
      foreach (got[i]) chk("t3_order", got[i], i);
      chk("t3_nolost", lost_cnt_o, 0);
      // loss while full, then clear beating a same-cycle loss
      do_reset();
      pulse(32'h0003_fc00);
      wait_n(10);
      chk("t4_full", fifo_level_o, 8);
      for (int k = 0; k < 3; k++) begin
         evt = 32'h1 << 4;
         @(negedge clk);
      end
      evt = '0;
      chk("t4_cnt", lost_cnt_o, 2);
      chk("t4_flag", lost_o, 1);
      evt = 32'h1 << 4;
      clr = 1'b1;
      @(negedge clk);
      evt = '0;
      clr = 1'b0;
      chk("t4_clr_cnt", lost_cnt_o, 0);
      chk("t4_clr_flag", lost_o, 0);
      ready = 1'b1;
      wait_n(15);
      chk("t4_drained", fifo_level_o, 0);
      // masking
      do_reset();
      ready = 1'b1;
      mask = ~(32'h1 << 6);
      pulse(32'h1 << 6);
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         seen |= event_valid_o;
      end
      chk("t5_masked_out", seen, 0);
      chk("t5_masked_lost", lost_cnt_o, 0);
      mask = '1;
      pulse(32'h1 << 2);
      mask = ~(32'h1 << 2);
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         seen |= event_valid_o;
      end
      chk("t5_blocked", seen, 0);
      mask = '1;
      @(negedge clk);
      chk("t5_unmask_valid", event_valid_o, 1);
      chk("t5_unmask_data", event_data_o, 2);
      // asynchronous reset mid-operation
      do_reset();
      pulse(32'h3ff0_0000);
      wait_n(5);
      chk("t6_queued", fifo_level_o, 5);
      #2 rst = 1'b1;
      #1;
      chk("t6_async_valid", event_valid_o, 0);
      chk("t6_async_level", fifo_level_o, 0);
      @(negedge clk);
      rst = 1'b0;
      ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         seen |= event_valid_o;
      end
      chk("t6_no_stale", seen, 0);
      chk("t6_level", fifo_level_o, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
